// File: rtl/lwe_mode_sequencer.sv
// Command sequencer for the LWE mode controller: accept op, settle mode, start engine, report status.
// Optional LWE_SEQ_PERF_EN adds a perf_cycles port with the RUN-cycle count of the last command.
module lwe_mode_sequencer #(
   parameter int SETTLE_CYCLES  = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_op,
   output logic       cmd_ready,
   input  logic       abort,
   output logic [1:0] mode,
   output logic       ctl_rst,
   output logic       engine_start,
   input  logic       engine_done,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_op,
   output logic [1:0] rsp_status,
   output logic       busy
`ifdef LWE_SEQ_PERF_EN
   ,
   output logic [31:0] perf_cycles
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [SW-1:0] S_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [1:0] ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_ABORT = 2'b10;

   typedef enum logic [2:0] {IDLE, SETTLE, START, RUN, RESP} state_t;
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] status;
   } rsp_t;

   state_t        state, state_nxt;
   logic [1:0]    exit_status;
   logic [TW-1:0] timer;
   logic [SW-1:0] settle_cnt;
   rsp_t          rsp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // RUN exit priority: done beats abort beats timeout
   always_comb begin
      state_nxt   = state;
      exit_status = ST_OK;
      case (state)
         IDLE:   if (cmd_valid) state_nxt = SETTLE;
         SETTLE: begin
            if (abort) begin
               state_nxt   = RESP;
               exit_status = ST_ABORT;
            end else if (settle_cnt == '0) state_nxt = START;
         end
         START: begin
            if (abort) begin
               state_nxt   = RESP;
               exit_status = ST_ABORT;
            end else state_nxt = RUN;
         end
         RUN: begin
            if (engine_done) state_nxt = RESP;
            else if (abort) begin
               state_nxt   = RESP;
               exit_status = ST_ABORT;
            end else if (timer == T_LAST) begin
               state_nxt   = RESP;
               exit_status = ST_TIMEOUT;
            end
         end
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready    = (state == IDLE);
      busy         = (state != IDLE);
      ctl_rst      = (state == IDLE) || (state == RESP);
      engine_start = (state == START);
      rsp_valid    = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode       <= 2'b00;
         rsp_q      <= '0;
         timer      <= '0;
         settle_cnt <= '0;
      end else begin
         if (state == IDLE && cmd_valid) begin
            mode       <= cmd_op;
            rsp_q.op   <= cmd_op;
            settle_cnt <= S_LOAD;
         end
         if (state == SETTLE && settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
         if (state == START) timer <= '0;
         if (state == RUN && state_nxt == RUN) timer <= timer + TW'(1);
         if (state != RESP && state_nxt == RESP) rsp_q.status <= exit_status;
      end
   end

   assign rsp_op     = rsp_q.op;
   assign rsp_status = rsp_q.status;

`ifdef LWE_SEQ_PERF_EN
   localparam int PW = (TW >= 32) ? TW + 1 : 33;
   logic [PW-1:0] run_len;
   assign run_len = PW'(timer) + PW'(1);

   // only RUN exits update the count; aborts before RUN leave the previous value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_cycles <= '0;
      else if (state == RUN && state_nxt == RESP)
         perf_cycles <= (|run_len[PW-1:32]) ? 32'hFFFF_FFFF : run_len[31:0];
   end
`endif

endmodule

// File: tb/tb_lwe_mode_sequencer.sv
// Directed bench for lwe_mode_sequencer: one instance with SETTLE_CYCLES=1 and one with 4, both TIMEOUT_CYCLES=16.
module tb_lwe_mode_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cmd_valid = 1'b0, cmd_valid4 = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic abort = 1'b0, abort4 = 1'b0;
   logic engine_done = 1'b0;
   logic rsp_ready = 1'b0;

   logic cmd_ready, ctl_rst, engine_start, rsp_valid, busy;
   logic [1:0] mode, rsp_op, rsp_status;
   logic cmd_ready4, ctl_rst4, engine_start4, rsp_valid4, busy4;
   logic [1:0] mode4, rsp_op4, rsp_status4;
`ifdef LWE_SEQ_PERF_EN
   logic [31:0] perf_cycles, perf_cycles4;
`endif

   int n_chk = 0, n_fail = 0;
   int starts = 0, starts4 = 0;

   always #5 clk = ~clk;

   lwe_mode_sequencer #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
      .abort(abort), .mode(mode), .ctl_rst(ctl_rst), .engine_start(engine_start),
      .engine_done(engine_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_op(rsp_op), .rsp_status(rsp_status), .busy(busy)
`ifdef LWE_SEQ_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   lwe_mode_sequencer #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_op(cmd_op), .cmd_ready(cmd_ready4),
      .abort(abort4), .mode(mode4), .ctl_rst(ctl_rst4), .engine_start(engine_start4),
      .engine_done(engine_done), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
      .rsp_op(rsp_op4), .rsp_status(rsp_status4), .busy(busy4)
`ifdef LWE_SEQ_PERF_EN
      , .perf_cycles(perf_cycles4)
`endif
   );

   always @(posedge clk) begin
      if (engine_start)  starts  <= starts + 1;
      if (engine_start4) starts4 <= starts4 + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_chk++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || engine_start !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl: busy=%b rsp_valid=%b start=%b, want 0 0 0", busy, rsp_valid, engine_start); end
      n_chk++; if (ctl_rst !== 1'b1 || mode !== 2'd0 || rsp_op !== 2'd0 || rsp_status !== 2'd0) begin
         n_fail++; $display("FAIL reset_data: ctl_rst=%b mode=%0d op=%0d st=%0d, want 1 0 0 0", ctl_rst, mode, rsp_op, rsp_status); end
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_release: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy); end
   endtask

   task automatic test_keygen();
      starts = 0;
      cmd_op = 2'd0; cmd_valid = 1'b1;
      tick();   // E0
      cmd_valid = 1'b0;
      n_chk++; if (busy !== 1'b1 || mode !== 2'd0 || ctl_rst !== 1'b0 || engine_start !== 1'b0) begin
         n_fail++; $display("FAIL keygen_settle: busy=%b mode=%0d ctl_rst=%b start=%b, want 1 0 0 0", busy, mode, ctl_rst, engine_start); end
      tick();   // E0+1
      n_chk++; if (engine_start !== 1'b1) begin
         n_fail++; $display("FAIL keygen_start: got %b want 1", engine_start); end
      tick();   // E0+2, RUN cycle 1
      n_chk++; if (engine_start !== 1'b0) begin
         n_fail++; $display("FAIL keygen_start_width: got %b want 0", engine_start); end
      repeat (9) tick();   // RUN cycle 10
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_op !== 2'd0 || rsp_status !== 2'b00 || ctl_rst !== 1'b1) begin
         n_fail++; $display("FAIL keygen_rsp: valid=%b op=%0d st=%b ctl_rst=%b, want 1 0 00 1", rsp_valid, rsp_op, rsp_status, ctl_rst); end
      n_chk++; if (starts !== 1) begin
         n_fail++; $display("FAIL keygen_start_count: got %0d want 1", starts); end
`ifdef LWE_SEQ_PERF_EN
      n_chk++; if (perf_cycles !== 32'd10) begin
         n_fail++; $display("FAIL keygen_perf: got %0d want 10", perf_cycles); end
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_chk++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL keygen_idle: cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_timeout();
      cmd_op = 2'd1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();        // RUN cycle 1
      repeat (15) tick();    // RUN cycle 16
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL timeout_early: rsp_valid=%b busy=%b, want 0 1", rsp_valid, busy); end
      tick();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_op !== 2'd1 || ctl_rst !== 1'b1) begin
         n_fail++; $display("FAIL timeout_rsp: valid=%b st=%b op=%0d ctl_rst=%b, want 1 01 1 1", rsp_valid, rsp_status, rsp_op, ctl_rst); end
`ifdef LWE_SEQ_PERF_EN
      n_chk++; if (perf_cycles !== 32'd16) begin
         n_fail++; $display("FAIL timeout_perf: got %0d want 16", perf_cycles); end
`endif
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_abort_settle();
      starts4 = 0;
      cmd_op = 2'd2; cmd_valid4 = 1'b1;
      tick();   // SETTLE cycle 1
      cmd_valid4 = 1'b0;
      cmd_op = 2'd0;
      tick();   // SETTLE cycle 2
      n_chk++; if (busy4 !== 1'b1 || ctl_rst4 !== 1'b0 || mode4 !== 2'd2) begin
         n_fail++; $display("FAIL abort_settle_pre: busy=%b ctl_rst=%b mode=%0d, want 1 0 2", busy4, ctl_rst4, mode4); end
      abort4 = 1'b1;
      tick();
      abort4 = 1'b0;
      n_chk++; if (rsp_valid4 !== 1'b1 || rsp_status4 !== 2'b10 || rsp_op4 !== 2'd2) begin
         n_fail++; $display("FAIL abort_settle_rsp: valid=%b st=%b op=%0d, want 1 10 2", rsp_valid4, rsp_status4, rsp_op4); end
      repeat (3) tick();
      n_chk++; if (starts4 !== 0 || rsp_valid4 !== 1'b1) begin
         n_fail++; $display("FAIL abort_settle_nostart: starts=%0d valid=%b, want 0 1", starts4, rsp_valid4); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      n_chk++; if (cmd_ready4 !== 1'b1) begin
         n_fail++; $display("FAIL abort_settle_idle: cmd_ready=%b want 1", cmd_ready4); end
   endtask

   task automatic test_done_priority();
      cmd_op = 2'd3; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();   // RUN cycle 2
      engine_done = 1'b1; abort = 1'b1;
      tick();
      engine_done = 1'b0; abort = 1'b0;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_op !== 2'd3) begin
         n_fail++; $display("FAIL done_abort_rsp: valid=%b st=%b op=%0d, want 1 00 3", rsp_valid, rsp_status, rsp_op); end
`ifdef LWE_SEQ_PERF_EN
      n_chk++; if (perf_cycles !== 32'd2) begin
         n_fail++; $display("FAIL done_abort_perf: got %0d want 2", perf_cycles); end
`endif
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      cmd_op = 2'd1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      repeat (15) tick();       // RUN cycle 16, timer 15
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_status !== 2'b00) begin
         n_fail++; $display("FAIL done_last_cycle: valid=%b st=%b, want 1 00", rsp_valid, rsp_status); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      cmd_op = 2'd2; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      cmd_op = 2'd1; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         n_chk++; if (rsp_valid !== 1'b1 || rsp_op !== 2'd2 || rsp_status !== 2'b00 || cmd_ready !== 1'b0 || mode !== 2'd2) begin
            n_fail++; $display("FAIL backpressure_hold[%0d]: valid=%b op=%0d st=%b cmd_ready=%b mode=%0d, want 1 2 00 0 2",
                               i, rsp_valid, rsp_op, rsp_status, cmd_ready, mode); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_chk++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_idle: cmd_ready=%b busy=%b valid=%b, want 1 0 0", cmd_ready, busy, rsp_valid); end
      tick();
      cmd_valid = 1'b0;
      n_chk++; if (busy !== 1'b1 || mode !== 2'd1) begin
         n_fail++; $display("FAIL backpressure_accept: busy=%b mode=%0d, want 1 1", busy, mode); end
      tick(); tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_op !== 2'd1) begin
         n_fail++; $display("FAIL backpressure_second: valid=%b op=%0d, want 1 1", rsp_valid, rsp_op); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      cmd_op = 2'd2; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (busy !== 1'b0 || ctl_rst !== 1'b1 || engine_start !== 1'b0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ctl: busy=%b ctl_rst=%b start=%b valid=%b, want 0 1 0 0", busy, ctl_rst, engine_start, rsp_valid); end
      n_chk++; if (mode !== 2'd0 || rsp_op !== 2'd0 || rsp_status !== 2'd0) begin
         n_fail++; $display("FAIL midrst_data: mode=%0d op=%0d st=%0d, want 0 0 0", mode, rsp_op, rsp_status); end
      #3 rst_n = 1'b1;
      repeat (3) tick();
      n_chk++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_norsp: valid=%b cmd_ready=%b, want 0 1", rsp_valid, cmd_ready); end
      cmd_op = 2'd3; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
      n_chk++; if (rsp_valid !== 1'b1 || rsp_op !== 2'd3 || rsp_status !== 2'b00) begin
         n_fail++; $display("FAIL midrst_next: valid=%b op=%0d st=%b, want 1 3 00", rsp_valid, rsp_op, rsp_status); end
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_keygen();
      test_timeout();
      test_abort_settle();
      test_done_priority();
      test_back_to_back();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
